sdi_video_extractor: RTL and testbench
======================================

Name: sdi_video_extractor

Overview:
Parametrised successor to the SDI-to-video stage. It sits between the SDI receiver and the video/3DNR pipeline in the clk_sdi domain. It converts the SMPTE luma/chroma word streams (ds1a/ds2a) plus TRS flags into a qualified parallel video stream with blanking, start-of-frame and end-of-line markers. Component width, active window and line length are configurable, and line-length errors are detected.

Parameters:
COMP_W, 8, output bits per component (1..10); vid_data width is 2*COMP_W.
VSTART_LINE, 42, rx_line_number of the first active line (inclusive).
VEND_LINE, 1122, rx_line_number at which active video ends (exclusive).
ACTIVE_PIX, 1920, expected active samples per line.
PIX_CNT_W, 12, width of the pixel counter; must satisfy 2^PIX_CNT_W > ACTIVE_PIX.

Ports:
clk_sdi  in  1  SDI word clock; the only clock.
rst_n  in  1  asynchronous active-low reset.
rx_ce  in  1  input sample qualifier; all rx_* inputs are ignored when 0.
rx_ds1a  in  10  data stream 1 (Y).
rx_ds2a  in  10  data stream 2 (C).
rx_trs  in  1  high on every TRS word (SAV and EAV).
rx_sav  in  1  high on the XYZ word of SAV.
rx_eav  in  1  high on the XYZ word of EAV.
rx_line_number  in  11  current line number.
err_clr  in  1  synchronous clear of the sticky error flags.
clk_vid  out  1  equal to clk_sdi (pass-through).
vid_hblank  out  1  high outside active pixels.
vid_vblank  out  1  high outside active lines.
vid_active_vid_en  out  1  qualifies vid_data.
vid_data  out  2*COMP_W  {C, Y}.
vid_sof  out  1  pulse on the first active pixel of a frame.
vid_eol  out  1  pulse on the last active pixel of a line.
vid_pix_cnt  out  PIX_CNT_W  index of the current active pixel.
err_short_line  out  1  sticky: a line ended before ACTIVE_PIX samples.
err_long_line  out  1  sticky: a line had more than ACTIVE_PIX samples.

Behaviour:
- Reset values:
  - vid_hblank = 1, vid_vblank = 1.
  - All other outputs = 0.
  - Horizontal FSM = H_BLANK, vvalid = 0, pixel counter = 0.
- Only cycles with rx_ce = 1 advance state. With rx_ce = 0:
  - state is held;
  - next-cycle vid_active_vid_en, vid_sof and vid_eol are 0;
  - vid_data, vid_hblank and vid_vblank hold.
- Vertical window:
  - vvalid is set on rx_ce & rx_sav & (line == VSTART_LINE).
  - vvalid is cleared on rx_ce & rx_sav & (line == VEND_LINE).
  - It changes only at SAV.
- Horizontal FSM:
  - H_BLANK: rx_ce & rx_sav -> H_ACTIVE with count = 0.
  - H_ACTIVE: each rx_ce & ~rx_trs sample is active and count increments.
    - The sample with count == ACTIVE_PIX-1 is active with eol = 1, then -> H_OVER.
    - rx_ce & rx_trs while in H_ACTIVE -> H_BLANK and sets err_short_line.
    - rx_ce & rx_sav while in H_ACTIVE (missing EAV) -> sets err_short_line, restarts H_ACTIVE with count = 0.
  - H_OVER: samples are not active.
    - The first rx_ce & ~rx_trs sample sets err_long_line.
    - rx_ce & rx_trs -> H_BLANK.
    - rx_ce & rx_sav -> H_ACTIVE with count = 0.
- Output pipeline:
  - Every output is registered; latency is exactly 1 cycle from the qualifying input sample.
  - vid_active_vid_en = active sample & vvalid.
  - vid_hblank = ~vid_active_vid_en. vid_vblank = ~vvalid, registered.
  - vid_pix_cnt = count of that sample.
  - vid_eol is only asserted together with vid_active_vid_en.
- vid_sof is asserted with vid_active_vid_en on count 0 of the first line after vvalid rises. It pulses once per frame.
- Component conversion (default): Y = rx_ds1a[9:10-COMP_W], C = rx_ds2a[9:10-COMP_W]. When COMP_W = 10 the data passes through unchanged.
- Sticky errors:
  - Set regardless of vvalid.
  - err_clr clears them.
  - If a set and err_clr occur in the same cycle, the set wins.
- If reset is asserted mid-line, all outputs return to reset values immediately. After reset release, no active output appears until the next SAV.

Optional Feature:
SDI_VIDEO_EXTRACTOR_ROUND_EN.
- Defined:
  - Each component is rounded half-up from 10 to COMP_W bits: add 2^(9-COMP_W) to the 10-bit value, then take bits [9:10-COMP_W].
  - On carry out the result saturates to all-ones.
  - Latency is unchanged (1 cycle).
  - With COMP_W = 10 the data passes through unchanged.
- Undefined: plain truncation as described in Behaviour.

Test Plan:
1. Reset, then a full frame with lines 1..1125 at ACTIVE_PIX = 1920. Required response:
   - vid_active_vid_en asserted for 1920 cycles on lines 42..1121 only;
   - vid_sof exactly once;
   - vid_eol on pix_cnt 1919 of each active line;
   - no errors.
2. rx_ds1a = 10'h3FF, rx_ds2a = 10'h201, COMP_W = 8, macro undefined. Required response: vid_data = 16'h80FF one cycle later.
3. Same stimulus as test 2 with the macro defined, plus a second sample rx_ds1a = 10'h1FE. Required response:
   - first sample: vid_data = 16'h80FF (C: 0x201 + 2 = 0x203 -> 0x80; Y: 0x3FF saturates to 0xFF);
   - second sample: Y = 8'h80.
4. EAV after 1000 samples. Required response: err_short_line = 1 the next cycle; no vid_eol on that line; err_clr then returns it to 0.
5. 1930 samples before EAV. Required response: err_long_line = 1; active_en deasserted for samples 1920..1929.
6. rx_ce toggling 1/0 every cycle, plus rst_n pulsed low mid-line. Required response:
   - output rate halves and pixel count is still 1920 per line;
   - during reset, vid_hblank = vid_vblank = 1 and active_en = 0;
   - output resumes only after the next SAV.

Source files
------------

// File: rtl/sdi_video_extractor.sv
// Turns SDI ds1a/ds2a word streams and TRS flags into a qualified parallel video stream.
// Optional SDI_VIDEO_EXTRACTOR_ROUND_EN selects half-up rounding instead of truncation.
module sdi_video_extractor #(
    parameter int COMP_W      = 8,
    parameter int VSTART_LINE = 42,
    parameter int VEND_LINE   = 1122,
    parameter int ACTIVE_PIX  = 1920,
    parameter int PIX_CNT_W   = 12
) (
    input  logic                   clk_sdi,
    input  logic                   rst_n,
    input  logic                   rx_ce,
    input  logic [9:0]             rx_ds1a,
    input  logic [9:0]             rx_ds2a,
    input  logic                   rx_trs,
    input  logic                   rx_sav,
    input  logic                   rx_eav,
    input  logic [10:0]            rx_line_number,
    input  logic                   err_clr,
    output logic                   clk_vid,
    output logic                   vid_hblank,
    output logic                   vid_vblank,
    output logic                   vid_active_vid_en,
    output logic [2*COMP_W-1:0]    vid_data,
    output logic                   vid_sof,
    output logic                   vid_eol,
    output logic [PIX_CNT_W-1:0]   vid_pix_cnt,
    output logic                   err_short_line,
    output logic                   err_long_line
);

    typedef enum logic [1:0] {H_BLANK, H_ACTIVE, H_OVER} h_state_t;

    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(ACTIVE_PIX - 1);
    localparam logic [10:0]          VSTART   = 11'(VSTART_LINE);
    localparam logic [10:0]          VEND     = 11'(VEND_LINE);

    assign clk_vid = clk_sdi;

    logic [COMP_W-1:0] y_conv;
    logic [COMP_W-1:0] c_conv;

    generate
        if (COMP_W == 10) begin : g_pass
            assign y_conv = rx_ds1a[9 -: COMP_W];
            assign c_conv = rx_ds2a[9 -: COMP_W];
        end else begin : g_narrow
`ifdef SDI_VIDEO_EXTRACTOR_ROUND_EN
            localparam logic [10:0] HALF = 11'(1) << (9 - COMP_W);
            logic [10:0] y_sum;
            logic [10:0] c_sum;
            logic        unused_bits;
            assign y_sum  = {1'b0, rx_ds1a} + HALF;
            assign c_sum  = {1'b0, rx_ds2a} + HALF;
            // A carry out of bit 9 means the rounded value no longer fits: clamp.
            assign y_conv = y_sum[10] ? {COMP_W{1'b1}} : y_sum[9 -: COMP_W];
            assign c_conv = c_sum[10] ? {COMP_W{1'b1}} : c_sum[9 -: COMP_W];
            assign unused_bits = ^{y_sum, c_sum};
`else
            logic unused_bits;
            assign y_conv = rx_ds1a[9 -: COMP_W];
            assign c_conv = rx_ds2a[9 -: COMP_W];
            assign unused_bits = ^{rx_ds1a, rx_ds2a};
`endif
        end
    endgenerate

    h_state_t               h_state_q, h_state_d;
    logic [PIX_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   vvalid_q, vvalid_d;
    logic                   sof_arm_q, sof_arm_d;
    logic                   act_q, act_d;
    logic                   sof_q, sof_d;
    logic                   eol_q, eol_d;
    logic                   hblank_q, hblank_d;
    logic                   vblank_q, vblank_d;
    logic [2*COMP_W-1:0]    data_q, data_d;
    logic [PIX_CNT_W-1:0]   pix_q, pix_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;

    logic trs_any;
    logic act_sample;
    logic eol_sample;
    logic short_set;
    logic long_set;

    // EAV/SAV XYZ flags are treated as TRS words even if rx_trs is missed.
    assign trs_any = rx_trs | rx_sav | rx_eav;

    always_comb begin
        h_state_d   = h_state_q;
        cnt_d       = cnt_q;
        vvalid_d    = vvalid_q;
        sof_arm_d   = sof_arm_q;
        act_sample  = 1'b0;
        eol_sample  = 1'b0;
        short_set   = 1'b0;
        long_set    = 1'b0;
        act_d       = 1'b0;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        hblank_d    = hblank_q;
        vblank_d    = vblank_q;
        data_d      = data_q;
        pix_d       = pix_q;
        err_short_d = err_clr ? 1'b0 : err_short_q;
        err_long_d  = err_clr ? 1'b0 : err_long_q;

        if (rx_ce) begin
            if (rx_sav) begin
                if (rx_line_number == VSTART) begin
                    vvalid_d = 1'b1;
                    if (!vvalid_q) begin
                        sof_arm_d = 1'b1;
                    end
                end
                if (rx_line_number == VEND) begin
                    vvalid_d = 1'b0;
                end
            end

            case (h_state_q)
                H_BLANK: begin
                    if (rx_sav) begin
                        h_state_d = H_ACTIVE;
                        cnt_d     = '0;
                    end
                end
                H_ACTIVE: begin
                    if (rx_sav) begin
                        short_set = 1'b1;
                        cnt_d     = '0;
                    end else if (trs_any) begin
                        short_set = 1'b1;
                        h_state_d = H_BLANK;
                    end else begin
                        act_sample = 1'b1;
                        if (cnt_q == LAST_PIX) begin
                            eol_sample = 1'b1;
                            h_state_d  = H_OVER;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                H_OVER: begin
                    if (rx_sav) begin
                        h_state_d = H_ACTIVE;
                        cnt_d     = '0;
                    end else if (trs_any) begin
                        h_state_d = H_BLANK;
                    end else begin
                        long_set = 1'b1;
                    end
                end
                default: begin
                    h_state_d = H_BLANK;
                end
            endcase

            act_d = act_sample & vvalid_q;
            eol_d = eol_sample & vvalid_q;
            sof_d = act_d & sof_arm_q & (cnt_q == '0);
            if (sof_d || !vvalid_d) begin
                sof_arm_d = 1'b0;
            end

            hblank_d = ~act_d;
            vblank_d = ~vvalid_d;
            data_d   = {c_conv, y_conv};
            if (act_sample) begin
                pix_d = cnt_q;
            end
        end

        // A new error in the same cycle as err_clr must not be lost.
        if (short_set) begin
            err_short_d = 1'b1;
        end
        if (long_set) begin
            err_long_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sdi or negedge rst_n) begin
        if (!rst_n) begin
            h_state_q   <= H_BLANK;
            cnt_q       <= '0;
            vvalid_q    <= 1'b0;
            sof_arm_q   <= 1'b0;
            act_q       <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            data_q      <= '0;
            pix_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            h_state_q   <= h_state_d;
            cnt_q       <= cnt_d;
            vvalid_q    <= vvalid_d;
            sof_arm_q   <= sof_arm_d;
            act_q       <= act_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            data_q      <= data_d;
            pix_q       <= pix_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign vid_hblank        = hblank_q;
    assign vid_vblank        = vblank_q;
    assign vid_active_vid_en = act_q;
    assign vid_data          = data_q;
    assign vid_sof           = sof_q;
    assign vid_eol           = eol_q;
    assign vid_pix_cnt       = pix_q;
    assign err_short_line    = err_short_q;
    assign err_long_line     = err_long_q;

endmodule

// File: tb/tb_sdi_video_extractor.sv
// Directed bench for sdi_video_extractor using a scaled-down raster (20 pixels, lines 3..5 active).
// Expected data values follow the SDI_VIDEO_EXTRACTOR_ROUND_EN setting of the build.
module tb_sdi_video_extractor;

    localparam int CW  = 8;
    localparam int VS  = 3;
    localparam int VE  = 6;
    localparam int AP  = 20;
    localparam int PCW = 5;
    localparam int NLINES = 8;

    logic              clk_sdi = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_ce = 1'b0;
    logic [9:0]        rx_ds1a = '0;
    logic [9:0]        rx_ds2a = '0;
    logic              rx_trs = 1'b0;
    logic              rx_sav = 1'b0;
    logic              rx_eav = 1'b0;
    logic [10:0]       rx_line_number = '0;
    logic              err_clr = 1'b0;
    logic              clk_vid;
    logic              vid_hblank;
    logic              vid_vblank;
    logic              vid_active_vid_en;
    logic [2*CW-1:0]   vid_data;
    logic              vid_sof;
    logic              vid_eol;
    logic [PCW-1:0]    vid_pix_cnt;
    logic              err_short_line;
    logic              err_long_line;

    sdi_video_extractor #(
        .COMP_W(CW), .VSTART_LINE(VS), .VEND_LINE(VE), .ACTIVE_PIX(AP), .PIX_CNT_W(PCW)
    ) dut (
        .clk_sdi(clk_sdi), .rst_n(rst_n), .rx_ce(rx_ce), .rx_ds1a(rx_ds1a), .rx_ds2a(rx_ds2a),
        .rx_trs(rx_trs), .rx_sav(rx_sav), .rx_eav(rx_eav), .rx_line_number(rx_line_number),
        .err_clr(err_clr), .clk_vid(clk_vid), .vid_hblank(vid_hblank), .vid_vblank(vid_vblank),
        .vid_active_vid_en(vid_active_vid_en), .vid_data(vid_data), .vid_sof(vid_sof),
        .vid_eol(vid_eol), .vid_pix_cnt(vid_pix_cnt), .err_short_line(err_short_line),
        .err_long_line(err_long_line)
    );

    always #5 clk_sdi = ~clk_sdi;

    int n_vec = 0;
    int n_err = 0;
    int line_act = 0;
    int n_sof = 0;
    int n_eol = 0;
    bit ce_toggle = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sdi);
        #1;
        if (vid_active_vid_en) line_act++;
        if (vid_sof) n_sof++;
        if (vid_eol) begin
            n_eol++;
            check("eol_pix_cnt", 32'(vid_pix_cnt), AP - 1);
            check("eol_with_active", 32'(vid_active_vid_en), 1);
        end
    endtask

    task automatic send_word(input logic [9:0] d1, input logic [9:0] d2, input logic trs,
                             input logic sav, input logic eav, input int line);
        rx_ce = 1'b1;
        rx_ds1a = d1;
        rx_ds2a = d2;
        rx_trs = trs;
        rx_sav = sav;
        rx_eav = eav;
        rx_line_number = 11'(line);
        tick();
        rx_trs = 1'b0;
        rx_sav = 1'b0;
        rx_eav = 1'b0;
        if (ce_toggle) begin
            rx_ce = 1'b0;
            tick();
        end
    endtask

    task automatic send_trs(input int line, input bit is_sav);
        send_word(10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, line);
        send_word(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, line);
        send_word(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, line);
        send_word(is_sav ? 10'h200 : 10'h274, 10'h200, 1'b1, is_sav, ~is_sav, line);
    endtask

    task automatic send_pix(input int line, input int n);
        for (int i = 0; i < n; i++) begin
            send_word(10'(10'h040 + i), 10'h200, 1'b0, 1'b0, 1'b0, line);
        end
    endtask

    task automatic send_line(input int line, input int exp_act);
        line_act = 0;
        send_trs(line, 1'b1);
        send_pix(line, AP);
        send_trs(line, 1'b0);
        for (int i = 0; i < 4; i++) send_word(10'h040, 10'h200, 1'b0, 1'b0, 1'b0, line);
        $display("line %0d: %0d active samples", line, line_act);
        check("line_active_count", line_act, exp_act);
    endtask

    task automatic send_frame(input string tag);
        int sof0;
        int eol0;
        sof0 = n_sof;
        eol0 = n_eol;
        for (int l = 1; l <= NLINES; l++) begin
            send_line(l, (l >= VS && l < VE) ? AP : 0);
        end
        $display("frame %s: sof=%0d eol=%0d", tag, n_sof - sof0, n_eol - eol0);
        check("frame_sof_count", n_sof - sof0, 1);
        check("frame_eol_count", n_eol - eol0, VE - VS);
        check("frame_end_vblank", 32'(vid_vblank), 1);
    endtask

    task automatic clear_errors();
        rx_ce = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    logic [15:0] exp_d2;
    logic [15:0] exp_d3;
    int eol_base;
    int sof_base;

    initial begin
`ifdef SDI_VIDEO_EXTRACTOR_ROUND_EN
        exp_d2 = 16'h8080;
        exp_d3 = 16'h0100;
`else
        exp_d2 = 16'h807F;
        exp_d3 = 16'h0000;
`endif
        // reset state
        tick();
        tick();
        check("rst_hblank", 32'(vid_hblank), 1);
        check("rst_vblank", 32'(vid_vblank), 1);
        check("rst_active", 32'(vid_active_vid_en), 0);
        check("rst_data", 32'(vid_data), 0);
        check("rst_sof_eol", 32'({vid_sof, vid_eol}), 0);
        check("rst_pix_cnt", 32'(vid_pix_cnt), 0);
        check("rst_errors", 32'({err_short_line, err_long_line}), 0);
        rst_n = 1'b1;

        // full frame
        send_frame("normal");
        check("frame_errors", 32'({err_short_line, err_long_line}), 0);

        // component conversion
        send_word(10'h3FF, 10'h201, 1'b0, 1'b0, 1'b0, NLINES);
        $display("conv 3FF/201 -> %h", vid_data);
        check("conv_sat", 32'(vid_data), 16'h80FF);
        send_word(10'h1FE, 10'h201, 1'b0, 1'b0, 1'b0, NLINES);
        $display("conv 1FE/201 -> %h", vid_data);
        check("conv_half", 32'(vid_data), 32'(exp_d2));
        send_word(10'h000, 10'h003, 1'b0, 1'b0, 1'b0, NLINES);
        $display("conv 000/003 -> %h", vid_data);
        check("conv_low", 32'(vid_data), 32'(exp_d3));
        rx_ce = 1'b0;
        rx_ds1a = 10'h155;
        rx_ds2a = 10'h2AA;
        tick();
        check("ce_low_data_hold", 32'(vid_data), 32'(exp_d3));
        check("ce_low_active", 32'(vid_active_vid_en), 0);

        // short line
        eol_base = n_eol;
        line_act = 0;
        send_trs(VS, 1'b1);
        check("short_vblank_low", 32'(vid_vblank), 0);
        send_pix(VS, 10);
        check("short_before_eav", 32'(err_short_line), 0);
        send_word(10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, VS);
        $display("short line: active=%0d err_short=%0b", line_act, err_short_line);
        check("short_flag", 32'(err_short_line), 1);
        send_word(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, VS);
        send_word(10'h000, 10'h000, 1'b1, 1'b0, 1'b0, VS);
        send_word(10'h274, 10'h200, 1'b1, 1'b0, 1'b1, VS);
        check("short_active_count", line_act, 10);
        check("short_no_eol", n_eol - eol_base, 0);
        clear_errors();
        check("short_cleared", 32'(err_short_line), 0);

        // long line, with err_clr colliding with the first overrun sample
        eol_base = n_eol;
        line_act = 0;
        send_trs(VS + 1, 1'b1);
        send_pix(VS + 1, AP);
        check("long_before_over", 32'(err_long_line), 0);
        err_clr = 1'b1;
        send_pix(VS + 1, 1);
        err_clr = 1'b0;
        check("long_set_beats_clr", 32'(err_long_line), 1);
        check("long_over_inactive", 32'(vid_active_vid_en), 0);
        send_pix(VS + 1, 9);
        send_trs(VS + 1, 1'b0);
        $display("long line: active=%0d err_long=%0b", line_act, err_long_line);
        check("long_active_count", line_act, AP);
        check("long_one_eol", n_eol - eol_base, 1);
        check("long_no_short", 32'(err_short_line), 0);
        clear_errors();
        check("long_cleared", 32'(err_long_line), 0);
        send_line(VE, 0);

        // half-rate input
        ce_toggle = 1'b1;
        send_frame("half_rate");
        check("half_rate_errors", 32'({err_short_line, err_long_line}), 0);

        // reset mid-line
        line_act = 0;
        send_trs(VS, 1'b1);
        send_pix(VS, 5);
        check("pre_reset_active_count", line_act, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hblank", 32'(vid_hblank), 1);
        check("mid_rst_vblank", 32'(vid_vblank), 1);
        check("mid_rst_active", 32'(vid_active_vid_en), 0);
        tick();
        tick();
        check("mid_rst_active_held", 32'(vid_active_vid_en), 0);
        rst_n = 1'b1;
        line_act = 0;
        send_pix(VS, 5);
        send_trs(VS, 1'b0);
        $display("after reset release: active=%0d", line_act);
        check("post_rst_no_active", line_act, 0);
        sof_base = n_sof;
        send_line(VS, AP);
        check("post_rst_sof", n_sof - sof_base, 1);
        check("post_rst_vblank", 32'(vid_vblank), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
